// File: rtl/freq_gen.sv
// Programmable square-wave source: BCD Hz setpoint -> binary -> half-period -> 50% wave.
// Define FREQ_GEN_CNT_EN to add the edge_cnt rising-edge counter port.
module freq_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] freq_bcd,
  output logic        sig_out,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef FREQ_GEN_CNT_EN
  ,
  output logic [31:0] edge_cnt
`endif
);

  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DIV, S_CHECK} state_t;

  state_t      state_q;
  logic [4:0]  step_q;
  logic [23:0] bcd_q;
  logic [19:0] acc_q;
  logic        inv_q;
  logic [20:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] pend_q;
  logic        busy_q, done_q, err_q;

  logic [31:0] act_q, cnt_q;
  logic        sig_q;

  logic [3:0]  digit;
  logic [19:0] acc_d;
  logic [20:0] divisor;
  logic [21:0] rem_sh;
  logic        ge;
  logic        f_zero;
  logic        accept;
  logic        commit;
  logic        wrap;

  always_comb begin
    digit   = bcd_q[23:20];
    acc_d   = (acc_q << 3) + (acc_q << 1) + {16'b0, digit};
    divisor = {acc_q, 1'b0};
    // Quotient bits shift in at the bottom while dividend bits leave from the top.
    rem_sh  = {rem_q, quo_q[31]};
    ge      = rem_sh >= {1'b0, divisor};
    f_zero  = (acc_q == '0);
    accept  = !inv_q && (f_zero || (quo_q != '0));
    commit  = (state_q == S_CHECK) && accept;
    wrap    = (act_q != '0) && (cnt_q == act_q - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      bcd_q   <= '0;
      acc_q   <= '0;
      inv_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            bcd_q   <= freq_bcd;
            acc_q   <= '0;
            inv_q   <= 1'b0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          acc_q  <= acc_d;
          bcd_q  <= {bcd_q[19:0], 4'h0};
          step_q <= step_q + 5'd1;
          if (digit > 4'd9) inv_q <= 1'b1;
          if (step_q == 5'd5) begin
            step_q  <= '0;
            rem_q   <= '0;
            quo_q   <= DIVIDEND;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q  <= ge ? 21'(rem_sh - {1'b0, divisor}) : rem_sh[20:0];
          quo_q  <= {quo_q[30:0], ge};
          step_q <= step_q + 5'd1;
          if (step_q == 5'd31) state_q <= S_CHECK;
        end
        default: begin
          // f=0 runs the divider anyway for fixed latency; its quotient is ignored.
          err_q   <= !accept;
          if (accept) pend_q <= f_zero ? '0 : quo_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= '0;
      cnt_q <= '0;
      sig_q <= 1'b0;
    end else if (act_q == '0) begin
      act_q <= pend_q;
      cnt_q <= '0;
      sig_q <= 1'b0;
    end else if (wrap) begin
      // New half-period only takes effect at a toggle, so no runt pulses.
      act_q <= pend_q;
      cnt_q <= '0;
      sig_q <= (pend_q == '0) ? 1'b0 : !sig_q;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

`ifdef FREQ_GEN_CNT_EN
  logic [31:0] edge_q;

  always_ff @(posedge clk) begin
    if (rst)                                    edge_q <= '0;
    else if (commit)                            edge_q <= '0;
    else if (wrap && (pend_q != '0) && !sig_q)  edge_q <= edge_q + 32'd1;
  end

  assign edge_cnt = edge_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
`endif

  assign sig_out = sig_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen at CLK_HZ = 1 MHz: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_freq_gen;
  localparam int HZ = 1_000_000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load = 1'b0;
  logic [23:0] freq_bcd = '0;
  logic sig_out, busy, done, err;
`ifdef FREQ_GEN_CNT_EN
  logic [31:0] edge_cnt;
`endif

  freq_gen #(.CLK_HZ(HZ)) dut (
    .clk(clk), .rst(rst), .load(load), .freq_bcd(freq_bcd),
    .sig_out(sig_out), .busy(busy), .done(done), .err(err)
`ifdef FREQ_GEN_CNT_EN
    , .edge_cnt(edge_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rise_cyc = 0, fall_cyc = 0, rise_cnt = 0, fall_cnt = 0, done_cnt = 0;
  logic prev_sig = 1'b0;

  typedef struct {
    logic [23:0] bcd;
    logic        e;
    int          half;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All sampling happens here, on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sig_out && !prev_sig) begin rise_cnt++; rise_cyc = cyc; end
    if (!sig_out && prev_sig) begin fall_cnt++; fall_cyc = cyc; end
    prev_sig = sig_out;
    if (done) done_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] bcd, input int dup_at, input logic [23:0] dup_bcd,
                         output int d_cyc);
    int lat;
    logic busy_ok;
    lat = 0; busy_ok = 1'b1; d_cyc = cyc;
    freq_bcd = bcd; load = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == dup_at) begin load = 1'b1; freq_bcd = dup_bcd; end
      else load = 1'b0;
      if (done) begin lat = k; d_cyc = cyc; break; end
      if (!busy) busy_ok = 1'b0;
    end
    load = 1'b0;
    chk("done_latency", lat, 40);
    chk("busy_during_calc", busy_ok, 1);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic wait_rise(input int bound);
    int r0 = rise_cnt;
    logic ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (rise_cnt != r0) begin ok = 1'b1; break; end
    end
    chk("rise_timeout", ok, 1);
  endtask

  task automatic wait_fall(input int bound);
    int f0 = fall_cnt;
    logic ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (fall_cnt != f0) begin ok = 1'b1; break; end
    end
    chk("fall_timeout", ok, 1);
  endtask

  initial begin
    int d, r0, dc0, t0;
    logic bad;

    // half = floor(1e6 / (2*f)); 0 marks stop or reject
    tbl[0] = '{24'h001000, 1'b0, 500};
    tbl[1] = '{24'h500000, 1'b0, 1};
    tbl[2] = '{24'h600000, 1'b1, 0};
    tbl[3] = '{24'h00000A, 1'b1, 0};
    tbl[4] = '{24'h000000, 1'b0, 0};
    tbl[5] = '{24'h002000, 1'b0, 250};
    tbl[6] = '{24'h012345, 1'b0, 40};
    tbl[7] = '{24'h000777, 1'b0, 643};
    tbl[8] = '{24'h0A0000, 1'b1, 0};
    tbl[9] = '{24'h250000, 1'b0, 2};

    // Reset and idle
    do_reset();
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (sig_out || busy || done || err) bad = 1'b1;
`ifdef FREQ_GEN_CNT_EN
      if (edge_cnt != 0) bad = 1'b1;
`endif
    end
    chk("idle_outputs_zero", bad, 0);

    // Table: each vector from a fresh reset
    foreach (tbl[i]) begin
      do_reset();
      do_load(tbl[i].bcd, 0, 24'h0, d);
      chk($sformatf("v%0d_err", i), err, tbl[i].e);
      if (tbl[i].half > 0) begin
        wait_rise(2 * tbl[i].half + 20);
        chk($sformatf("v%0d_first_rise", i), rise_cyc - d, tbl[i].half + 1);
        wait_fall(2 * tbl[i].half + 20);
        chk($sformatf("v%0d_high", i), fall_cyc - rise_cyc, tbl[i].half);
        wait_rise(2 * tbl[i].half + 20);
        chk($sformatf("v%0d_low", i), rise_cyc - fall_cyc, tbl[i].half);
      end else begin
        r0 = rise_cnt;
        repeat (30) tick();
        chk($sformatf("v%0d_no_rise", i), rise_cnt - r0, 0);
        chk($sformatf("v%0d_sig_low", i), sig_out, 0);
      end
    end

    // Too-high frequency rejected; 2-cycle period kept, err holds
    do_reset();
    do_load(24'h500000, 0, 24'h0, d);
    wait_rise(10);
    do_load(24'h600000, 0, 24'h0, d);
    chk("hi_err", err, 1);
    wait_fall(10);
    wait_rise(10);
    chk("hi_keep_low", rise_cyc - fall_cyc, 1);
    wait_fall(10);
    chk("hi_keep_high", fall_cyc - rise_cyc, 1);
    repeat (20) tick();
    chk("err_holds", err, 1);

    // Invalid digit while running, with an ignored second load during busy
    do_reset();
    do_load(24'h001000, 0, 24'h0, d);
    wait_rise(1100);
    dc0 = done_cnt;
    do_load(24'h00000A, 10, 24'h002000, d);
    chk("inv_err", err, 1);
    repeat (60) tick();
    chk("single_done", done_cnt - dc0, 1);
    wait_fall(1100);
    chk("inv_high_kept", fall_cyc - rise_cyc, 500);
    wait_rise(1100);
    chk("inv_low_kept", rise_cyc - fall_cyc, 500);

    // Mid-half change to 2000 Hz
    t0 = rise_cyc;
    repeat (100) tick();
    do_load(24'h002000, 0, 24'h0, d);
    chk("chg_err", err, 0);
    wait_fall(600);
    chk("chg_old_half", fall_cyc - t0, 500);
    wait_rise(600);
    chk("chg_new_low", rise_cyc - fall_cyc, 250);
    wait_fall(600);
    chk("chg_new_high", fall_cyc - rise_cyc, 250);

    // Stop while running
    wait_rise(600);
    t0 = rise_cyc;
    do_load(24'h000000, 0, 24'h0, d);
    chk("stop_err", err, 0);
`ifdef FREQ_GEN_CNT_EN
    chk("stop_edge_cleared", edge_cnt, 0);
`endif
    wait_fall(600);
    chk("stop_at_boundary", fall_cyc - t0, 250);
    r0 = rise_cnt;
    repeat (600) tick();
    chk("stop_no_rise", rise_cnt - r0, 0);
    chk("stop_sig_low", sig_out, 0);
`ifdef FREQ_GEN_CNT_EN
    chk("stop_edge_frozen", edge_cnt, 0);

    // Edge counter over three periods
    do_reset();
    do_load(24'h001000, 0, 24'h0, d);
    chk("edge_zero_at_done", edge_cnt, 0);
    wait_rise(1100); wait_rise(1100); wait_rise(1100);
    chk("edge_three", edge_cnt, 3);
`endif

    // Reset mid-computation aborts and discards
    do_reset();
    freq_bcd = 24'h500000; load = 1'b1;
    tick(); load = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("abort_busy", busy, 0);
    dc0 = done_cnt; r0 = rise_cnt;
    repeat (60) tick();
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_no_wave", rise_cnt - r0, 0);

    // Load coincident with reset is dropped
    rst = 1'b1; load = 1'b1; freq_bcd = 24'h001000;
    tick();
    rst = 1'b0; load = 1'b0;
    chk("rstload_busy", busy, 0);
    dc0 = done_cnt;
    repeat (50) tick();
    chk("rstload_no_done", done_cnt - dc0, 0);

    // Reset while running forces output low
    do_reset();
    do_load(24'h500000, 0, 24'h0, d);
    wait_rise(10);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("run_rst_sig", sig_out, 0);
    r0 = rise_cnt;
    repeat (20) tick();
    chk("run_rst_stopped", rise_cnt - r0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_gen.md
# freq_gen

Programmable square-wave source; the transmit-side counterpart of the six-digit frequency counter. Accepts a six-digit BCD frequency in Hz, converts it to binary, divides the system clock down to a half-period count, and drives a 50 % duty square wave on `sig_out`. Intended to loop back into the counter's `in` pin as a self-test stimulus, or to drive a header pin as a bench signal source.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz; must be < 2^32.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `load`  input  1  one-cycle strobe requesting a new frequency; sampled only when `busy`=0.
- `freq_bcd`  input  24  six BCD digits, [23:20] = 100 000s … [3:0] = units; sampled in the `load` cycle.
- `sig_out`  output  1  generated square wave.
- `busy`  output  1  high while a setpoint is being computed.
- `done`  output  1  one-cycle pulse when a computation finishes.
- `err`  output  1  result of the last computation; 1 = rejected.
- `edge_cnt`  output  32  rising edges of `sig_out`; present only with `FREQ_GEN_CNT_EN`.

## Operation
- Reset values: `sig_out`=0, `busy`=0, `done`=0, `err`=0, `edge_cnt`=0. Active half-period is 0 (stopped) and the pending register is empty.
- FSM states and transitions:
  - IDLE: `load`=1 latches `freq_bcd` and goes to CONV. `load` while `busy`=1 is ignored and has no effect.
  - CONV: 6 cycles, MSD first; `acc = acc*10 + digit`, computed as `(acc<<3)+(acc<<1)+digit` in 20 bits. Any digit > 9 sets an internal invalid flag. Conversion continues to the end so latency stays fixed.
  - DIV: 32 cycles of restoring division, one quotient bit per cycle. Dividend is `CLK_HZ` (32 b); divisor is `2*acc` (21 b). Result `half = floor(CLK_HZ/(2*f))`.
  - CHECK: 1 cycle, then return to IDLE with `done`=1.
- Division is skipped logically when f=0: the divider still runs, but its result is discarded.
- Accept/reject at CHECK:
  - Invalid digit: `err`=1. Pending register is unchanged and the running output is unaffected.
  - f>0 and `half`=0 (f > CLK_HZ/2): `err`=1. Pending register and output are unaffected.
  - f=0: `err`=0. Pending = 0 (stop).
  - Otherwise: `err`=0. Pending = `half`.
- `err` is updated only at `done` and holds until the next `done`.
- Wave generator:
  - Counter `cnt` runs 0…active−1. At `cnt`=active−1: toggle `sig_out`, set `cnt` to 0, and copy pending into active.
  - A new frequency therefore takes effect at the next toggle. The current half-period always completes with the old value, so no glitch or runt is possible.
  - If active = 0 (stopped), a committed pending value is copied into active on the cycle after `done`. `sig_out` starts low and goes high after the first half-period.
  - If pending = 0 is committed while running, the generator stops at the next toggle boundary. At the stop, `sig_out` is forced to 0 and `cnt` is cleared to 0.
- Output period is exactly 2×active cycles. Actual frequency is `CLK_HZ/(2*active)`, truncated (rounded down).

## Timing
- Load is sampled in cycle N. `busy` is high in cycles N+1 … N+39. `done` pulses in cycle N+40, with `busy`=0 in that same cycle.
- `busy` is low in cycle N+40, so a new `load` is accepted as early as N+40.
- `sig_out` is registered and changes exactly at counter wrap; there is no combinational path from any input to `sig_out`.
- Reset mid-computation aborts to IDLE. All outputs return to their reset values in the next cycle, and the pending value is discarded.
- `load` asserted in the same cycle as `rst`: `rst` wins and the load is dropped.

## Configuration
- `FREQ_GEN_CNT_EN` defined:
  - Adds the `edge_cnt` port, incremented on every 0→1 transition of `sig_out`.
  - Cleared to 0 at each accepted (`err`=0) `done`.
  - Wraps modulo 2^32.
- `FREQ_GEN_CNT_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle for 100 cycles → `sig_out`=0, `busy`=0, `done`=0, `err`=0 throughout.
- Use `CLK_HZ`=1_000_000. Load `24'h001000` at cycle N → `done` at N+40, `err`=0. `sig_out` rises 500 cycles after commit, with period 1000 and high time 500. With `FREQ_GEN_CNT_EN`, `edge_cnt`=3 after 3 periods.
- Use `CLK_HZ`=1_000_000. Load `24'h500000` → period 2 cycles. Then load `24'h600000` → `err`=1 and the output keeps a 2-cycle period.
- While running at 1000 Hz, load `24'h00000A` → `err`=1 and the waveform is unchanged. A second `load` pulsed while `busy`=1 is ignored: only one `done` occurs.
- While running at 1000 Hz, load `24'h002000` mid half-period → the current half completes at 500 cycles, and subsequent halves are 250 cycles.
- Load `24'h000000` while running → `err`=0. `sig_out` goes and stays 0 after the current half completes, and `edge_cnt` stops incrementing.
